// File: rtl/dual_port_main_memory.sv
// Dual-port main memory: one fetch read port, one load read port, one store port.
// Clears itself after reset and only then accepts stores; reads are registered and write-first.
module dual_port_main_memory #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] read_address_0,
  input  logic [31:0] read_address_1,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data_0,
  output logic [31:0] read_data_1,
  output logic        ready,
  output logic        addr_error
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    return a[31:AW+2] == '0;
  endfunction

  logic [AW-1:0] widx, ridx0, ridx1;
  logic          wr_legal, wr_bad;
  logic [31:0]   rd0_nxt, rd1_nxt;
  logic          unused_bits;

  assign widx  = write_address[AW+1:2];
  assign ridx0 = read_address_0[AW+1:2];
  assign ridx1 = read_address_1[AW+1:2];
  assign unused_bits = ^{read_address_0[1:0], read_address_1[1:0]};

  assign wr_legal = (state == RUN) && write_enable &&
                    in_range(write_address) && (write_address[1:0] == 2'b00);
  assign wr_bad   = (state == RUN) && write_enable && !wr_legal;

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == AW'(DEPTH - 1)) state_nxt = RUN;
  end

  // Write-first: a same-edge legal store to the read word bypasses the array.
  always_comb begin
    rd0_nxt = '0;
    rd1_nxt = '0;
    if (in_range(read_address_0))
      rd0_nxt = (wr_legal && ridx0 == widx) ? write_data : mem[ridx0];
    if (in_range(read_address_1))
      rd1_nxt = (wr_legal && ridx1 == widx) ? write_data : mem[ridx1];
  end

  // The array itself is not reset; the CLEAR sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem[clr_idx] <= '0;
    else if (wr_legal)   mem[widx]    <= write_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      ready       <= 1'b0;
      addr_error  <= 1'b0;
      read_data_0 <= '0;
      read_data_1 <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clr_idx     <= clr_idx + 1'b1;
        read_data_0 <= '0;
        read_data_1 <= '0;
        if (state_nxt == RUN) ready <= 1'b1;
      end else begin
        read_data_0 <= rd0_nxt;
        read_data_1 <= rd1_nxt;
        if (wr_bad) addr_error <= 1'b1;
      end
    end
  end
endmodule

// File: doc/dual_port_main_memory.md
DUAL_PORT_MAIN_MEMORY -- requirements
Module: dual_port_main_memory

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: port clk clocks the block; port rst is asynchronous and active-high.
REQ-002 The block SHALL have parameter DEPTH: default 256; number of 32-bit words, power of two, 16..4096.
REQ-003 The block SHALL have port clk: input, 1 bit; rising-edge clock.
REQ-004 The block SHALL have port rst: input, 1 bit; asynchronous active-high reset.
REQ-005 The block SHALL have port read_address_0: input, 32 bits; byte address of the instruction fetch port.
REQ-006 The block SHALL have port read_address_1: input, 32 bits; byte address of the data load port.
REQ-007 The block SHALL have port write_address: input, 32 bits; byte address of the store port.
REQ-008 The block SHALL have port write_data: input, 32 bits; store data.
REQ-009 The block SHALL have port write_enable: input, 1 bit; store strobe, sampled at each rising clk edge.
REQ-010 The block SHALL have port read_data_0: output, 32 bits; registered word for read_address_0.
REQ-011 The block SHALL have port read_data_1: output, 32 bits; registered word for read_address_1.
REQ-012 The block SHALL have port ready: output, 1 bit; high once post-reset clearing completes.
REQ-013 The block SHALL have port addr_error: output, 1 bit; sticky flag for illegal store addresses.

Function
REQ-014 Word index SHALL be address[log2(DEPTH)+1:2]; an address is in range iff address < 4*DEPTH; bits [1:0] are ignored for reads.
REQ-015 The state machine SHALL have two states: CLEAR and RUN.
REQ-016 In CLEAR, a counter clr_idx SHALL write 0 to word clr_idx on each edge and then increment.
REQ-017 When the edge that writes word DEPTH-1 occurs, the state SHALL move to RUN and ready SHALL go high on that same edge, i.e. exactly DEPTH edges after rst deasserts.
REQ-018 In CLEAR, write_enable SHALL be ignored and read_data_0/1 SHALL load 0 on every edge.
REQ-019 In RUN, when write_enable=1 and write_address is in range with [1:0]=00, the word SHALL be written at the edge.
REQ-020 In RUN, a store with an out-of-range or misaligned write_address SHALL leave memory unchanged and set addr_error, which stays set until rst.
REQ-021 In RUN, read latency SHALL be one cycle: read_data_N SHALL show, after edge k, the word at the read_address_N sampled at edge k.
REQ-022 An out-of-range read address SHALL return 0 and SHALL NOT set addr_error.
REQ-023 A read on the same edge as a legal store to the same word index SHALL be write-first: read_data_N returns write_data. This applies independently on both ports, and when both ports hit the same word.
REQ-024 Both read ports SHALL be fully independent; identical addresses SHALL return identical data.
REQ-025 Outputs SHALL be registered only; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-026 While rst=1, the block SHALL hold state=CLEAR, clr_idx=0, ready=0, addr_error=0, and read_data_0=read_data_1=0, immediately and without waiting for clk.
REQ-027 If rst asserts mid-CLEAR or mid-RUN, the block SHALL abort the current operation, and the full clear sequence SHALL restart after deassertion, so all prior contents read as 0.

Verification
REQ-028 Reset clear: deassert rst with DEPTH=256 -> ready=0 for 255 edges and 1 after edge 256; reading 0x0 and 0x3FC returns 0.
REQ-029 Write/read: store 0xDEADBEEF to 0x40, then read 0x40 on port 1 next cycle -> read_data_1=0xDEADBEEF one edge later; port 0 at 0x44 reads 0.
REQ-030 Forwarding: same edge store 0x12345678 to 0x80 and both ports read 0x80 -> both outputs 0x12345678 after that edge.
REQ-031 Illegal stores: store to 0x402, then to 0x400 (DEPTH=256) -> addr_error=1 after the first, memory unchanged, flag stays 1; read 0x400 -> 0.
REQ-032 Writes during CLEAR: store 0xFFFFFFFF to 0x10 while ready=0 -> ignored; after ready, 0x10 reads 0.
REQ-033 Mid-run reset: write 0xA5A5A5A5 to 0x20, pulse rst between edges -> outputs 0 immediately, ready=0, and 0x20 reads 0 after ready returns.
